// File: rtl/vna_frame_packer_if.sv
// Byte-stream handshake between the VNA frame packer and its downstream consumer.
interface vna_frame_packer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sof;
  logic       out_eof;

  modport master (output out_data, output out_valid, output out_sof, output out_eof,
                  input  out_ready);
  modport slave  (input  out_data, input  out_valid, input  out_sof, input  out_eof,
                  output out_ready);
endinterface

// File: rtl/vna_frame_packer.sv
// Packs VNA I/Q samples into 512-byte frames: 3 sync, 5 C&C, 63 x 8-byte sample slots.
// Samples queue in a small FIFO; the byte stream stalls at slot boundaries when it runs dry.
module vna_frame_packer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] MIC_FILL   = 16'h0000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_strobe,
  input  logic [23:0]                 in_I,
  input  logic [23:0]                 in_Q,
  input  logic [39:0]                 cc_data,
  vna_frame_packer_if.master          stream,
  output logic                        overflow,
  output logic [15:0]                 frames_sent
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] CC     = 2'd2;
  localparam logic [1:0] SAMPLE = 2'd3;

  logic [47:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop, xfer;
  logic [47:0]   head;

  logic [1:0]    state;
  logic [2:0]    sub_cnt;
  logic [5:0]    slot_cnt;
  logic [39:0]   cc_reg;
  logic [47:0]   hold;

  logic [7:0]    data_c;
  logic          valid_c, sof_c, eof_c;

  // Full is judged on the registered count, so a same-cycle pop never rescues a strobe.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = fifo_mem[rd_ptr];
  assign push  = in_strobe & ~full;
  assign xfer  = valid_c & stream.out_ready;
  assign pop   = xfer & (state == SAMPLE) & (sub_cnt == 3'd0);

  always_ff @(posedge clock) begin
    if (!reset && push) fifo_mem[wr_ptr] <= {in_I, in_Q};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (!push && pop) count <= count - CNT_ONE;
      if (in_strobe && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      sub_cnt     <= '0;
      slot_cnt    <= '0;
      cc_reg      <= '0;
      hold        <= '0;
      frames_sent <= '0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          state   <= SYNC;
          cc_reg  <= cc_data;
          sub_cnt <= '0;
        end
        SYNC: if (xfer) begin
          if (sub_cnt == 3'd2) begin
            state   <= CC;
            sub_cnt <= '0;
          end else sub_cnt <= sub_cnt + 3'd1;
        end
        CC: if (xfer) begin
          if (sub_cnt == 3'd4) begin
            state    <= SAMPLE;
            sub_cnt  <= '0;
            slot_cnt <= '0;
          end else sub_cnt <= sub_cnt + 3'd1;
        end
        SAMPLE: if (xfer) begin
          if (sub_cnt == 3'd0) hold <= head;
          if (sub_cnt == 3'd7) begin
            sub_cnt <= '0;
            if (slot_cnt == 6'd62) begin
              state       <= IDLE;
              slot_cnt    <= '0;
              frames_sent <= frames_sent + 16'd1;
            end else slot_cnt <= slot_cnt + 6'd1;
          end else sub_cnt <= sub_cnt + 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state only, so they hold steady under backpressure.
  always_comb begin
    valid_c = 1'b0;
    data_c  = 8'h00;
    sof_c   = 1'b0;
    eof_c   = 1'b0;
    case (state)
      SYNC: begin
        valid_c = 1'b1;
        data_c  = 8'h7F;
        sof_c   = (sub_cnt == 3'd0);
      end
      CC: begin
        valid_c = 1'b1;
        case (sub_cnt)
          3'd0:    data_c = cc_reg[39:32];
          3'd1:    data_c = cc_reg[31:24];
          3'd2:    data_c = cc_reg[23:16];
          3'd3:    data_c = cc_reg[15:8];
          default: data_c = cc_reg[7:0];
        endcase
      end
      SAMPLE: begin
        valid_c = (sub_cnt != 3'd0) || !empty;
        case (sub_cnt)
          3'd0:    data_c = empty ? 8'h00 : head[47:40];
          3'd1:    data_c = hold[39:32];
          3'd2:    data_c = hold[31:24];
          3'd3:    data_c = hold[23:16];
          3'd4:    data_c = hold[15:8];
          3'd5:    data_c = hold[7:0];
          3'd6:    data_c = MIC_FILL[15:8];
          default: data_c = MIC_FILL[7:0];
        endcase
        eof_c = (sub_cnt == 3'd7) && (slot_cnt == 6'd62);
      end
      default: ;
    endcase
  end

  assign stream.out_data  = data_c;
  assign stream.out_valid = valid_c;
  assign stream.out_sof   = sof_c;
  assign stream.out_eof   = eof_c;

endmodule

// File: doc/vna_frame_packer.md
VNA_FRAME_PACKER -- requirements
Module: vna_frame_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: number of 48-bit I/Q sample slots buffered ahead of the byte stream (power of two, 2..16).
REQ-002 SHALL have parameter MIC_FILL, default 16'h0000: constant placed in the two mic bytes of every sample slot.
REQ-003 SHALL have port clock, input, 1: single clock for all logic.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_strobe, input, 1: one-cycle pulse marking a valid sample from the VNA scanner.
REQ-006 SHALL have port in_I, input, 24: signed I sample, sampled when in_strobe=1.
REQ-007 SHALL have port in_Q, input, 24: signed Q sample, sampled when in_strobe=1.
REQ-008 SHALL have port cc_data, input, 40: five C&C bytes, cc_data[39:32] sent first.
REQ-009 SHALL have port out_data, output, 8: stream byte.
REQ-010 SHALL have port out_valid, output, 1: out_data holds a valid byte.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts a byte; transfer = out_valid & out_ready.
REQ-012 SHALL have port out_sof, output, 1: high with byte 0 of a frame.
REQ-013 SHALL have port out_eof, output, 1: high with byte 511 of a frame.
REQ-014 SHALL have port overflow, output, 1: sticky, set when a sample is dropped.
REQ-015 SHALL have port frames_sent, output, 16: count of completed frames, wraps 0xFFFF->0.

Function
REQ-016 SHALL emit 512-byte frames: 7F 7F 7F, five C&C bytes, then 63 slots of 8 bytes each.
REQ-017 SHALL order each slot I[23:16], I[15:8], I[7:0], Q[23:16], Q[15:8], Q[7:0], MIC_FILL[15:8], MIC_FILL[7:0].
REQ-018 SHALL write {in_I,in_Q} into the FIFO on every in_strobe when the FIFO is not full at the start of that cycle; the new entry is visible the next cycle.
REQ-019 SHALL drop a sample whose strobe arrives while the FIFO is full, even if a pop occurs in the same cycle, and set overflow=1.
REQ-020 SHALL implement states IDLE, SYNC (3 bytes), CC (5 bytes), SAMPLE (504 bytes), with byte counters sync/cc 0..2/0..4 and slot 0..62, byte 0..7.
REQ-021 SHALL leave IDLE for SYNC on the cycle after the FIFO is seen non-empty, latching cc_data into a frame register on that same transition.
REQ-022 SHALL therefore present the first 7F with out_valid=1 exactly 2 cycles after the strobe that filled an empty FIFO in IDLE.
REQ-023 SHALL send the C&C bytes from the frame register only; cc_data changes mid-frame take effect in the next frame.
REQ-024 SHALL, in SAMPLE at slot byte 0, drive out_valid=1 only when the FIFO is non-empty, with out_data = head I[23:16]; otherwise out_valid=0 (stall, no filler).
REQ-025 SHALL, on transfer of slot byte 0, copy the head into a 48-bit hold register and pop it; slot bytes 1..5 come from the hold register, 6..7 from MIC_FILL.
REQ-026 SHALL, in SYNC, CC and slot bytes 1..7, keep out_valid=1 continuously.
REQ-027 SHALL hold out_data, out_sof, out_eof stable while out_valid=1 and out_ready=0.
REQ-028 SHALL advance exactly one byte per transfer and never otherwise.
REQ-029 SHALL, on transfer of byte 511, increment frames_sent and go to IDLE; the next frame then begins per REQ-021.
REQ-030 SHALL keep out_sof and out_eof low whenever out_valid=0.

Reset
REQ-031 SHALL, with reset=1 at a clock edge, set state IDLE, empty the FIFO, clear counters and hold register, and drive out_valid=0, out_data=0, out_sof=0, out_eof=0, overflow=0, frames_sent=0.
REQ-032 SHALL abandon any partial frame on reset, with no byte emitted after it, and SHALL ignore in_strobe in the reset cycle.

Verification
REQ-033 SHALL verify single sample, cc_data=0x0102030405, out_ready=1, I=0x123456, Q=0xFEDCBA -> bytes 7F 7F 7F 01 02 03 04 05 12 34 56 FE DC BA 00 00, sof on first byte, then out_valid=0 awaiting slot 1.
REQ-034 SHALL verify 63 strobes spaced 20 cycles, out_ready=1 -> exactly 512 transfers, eof on byte 511 only, frames_sent=1, state IDLE.
REQ-035 SHALL verify out_ready=0 for 100 cycles at byte 200 -> out_data/out_valid unchanged throughout, and the full frame is byte-exact afterwards.
REQ-036 SHALL verify out_ready=0 with 6 back-to-back strobes (samples A..F) -> overflow=1, and the stream carries only A..D.
REQ-037 SHALL verify reset asserted at byte 200 -> out_valid=0 next cycle, overflow=0, frames_sent=0, and the next strobe starts a new frame with 7F.
REQ-038 SHALL verify cc_data changed at byte 300 -> current frame unchanged, and the new C&C bytes appear in the following frame.
